// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a first-word-fall-through byte FIFO. The
// default frame is 8N1; defining UART_RX_PARITY_EN makes it 8E1 and adds o_parity_err.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_rx,
    output logic [7:0]                   o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [$clog2(FIFO_DEPTH):0]  o_count,
    output logic                         o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                         o_parity_err,
`endif
    output logic                         o_overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK, PARITY} state_t;
    localparam state_t AFTER_DATA = PARITY;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t state, next;
    logic [1:0] rst_q;
    logic rst_s, rx_m, rx_s, rx_d;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shreg;
    logic tick, fall, load_half, load_bit, shift, stop_smp, perr, push_q, pop, wr, full;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;

    // Reset asserts asynchronously but releases on a clock edge
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) rst_q <= 2'b00;
        else          rst_q <= {rst_q[0], 1'b1};
    assign rst_s = rst_q[1];

    // Two-flop synchroniser; it runs on the raw reset so it already tracks the
    // line when the FSM is released, letting a line held low stay ignored
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) {rx_s, rx_m} <= 2'b11;
        else          {rx_s, rx_m} <= {rx_m, i_rx};

    assign tick = cnt == '0;
    assign fall = rx_d & ~rx_s;

    // FSM state register
    always_ff @(posedge i_clk or negedge rst_s)
        if (!rst_s) state <= IDLE;
        else        state <= next;

    // FSM next-state logic
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (fall) next = START;
            START:   if (tick) next = rx_s ? IDLE : DATA;
            DATA:    if (tick && idx == 3'd7) next = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            PARITY:  if (tick) next = STOP;
`endif
            STOP:    if (tick) next = rx_s ? IDLE : BRK;
            BRK:     if (rx_s) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // FSM outputs: counter loads, data shift and stop-bit sample strobes
    always_comb begin
        load_half = state == IDLE && fall;
        load_bit  = tick && ((state == START && !rx_s) || state == DATA || state == AFTER_DATA);
        shift     = tick && state == DATA;
        stop_smp  = tick && state == STOP;
    end

    // Bit timing counter, bit index and shift register; the edge detector
    // history starts low so no edge is seen on the first cycle after reset
    always_ff @(posedge i_clk or negedge rst_s)
        if (!rst_s) begin
            rx_d  <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            rx_d  <= rx_s;
            cnt   <= load_half ? HALF_BIT : load_bit ? FULL_BIT : tick ? cnt : cnt - 1'b1;
            idx   <= state == DATA ? idx + 3'(shift) : 3'd0;
            if (shift) shreg <= {rx_s, shreg[7:1]};
        end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    // Capture the parity bit; even parity means the nine bits XOR to zero
    always_ff @(posedge i_clk or negedge rst_s)
        if (!rst_s)                       par_bit <= 1'b0;
        else if (tick && state == PARITY) par_bit <= rx_s;
    assign perr = ^{shreg, par_bit};
`else
    assign perr = 1'b0;
`endif

    // Stop-bit verdict: request a push or raise the error pulses
    always_ff @(posedge i_clk or negedge rst_s)
        if (!rst_s) begin
            push_q      <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
        end else begin
            push_q      <= stop_smp & rx_s & ~perr;
            o_frame_err <= stop_smp & ~rx_s;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= stop_smp & perr;
`endif
        end

    assign o_valid = o_count != '0;
    assign full    = o_count == (AW + 1)'(FIFO_DEPTH);
    assign pop     = o_valid & i_ready;
    assign wr      = push_q & (~full | pop);
    assign o_data  = mem[rp];

    // FIFO storage, pointers and occupancy; a push into a full FIFO with no pop is dropped
    always_ff @(posedge i_clk or negedge rst_s)
        if (!rst_s) begin
            mem       <= '{default: '0};
            wp        <= '0;
            rp        <= '0;
            o_count   <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (wr) mem[wp] <= shreg;
            wp        <= wp + AW'(wr);
            rp        <= rp + AW'(pop);
            o_count   <= o_count + (AW + 1)'(wr) - (AW + 1)'(pop);
            o_overrun <= push_q & full & ~pop;
        end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized self-checking bench for uart_rx_fifo against a queue-based frame model
module tb_uart_rx_fifo;
    localparam int C = 16;
    localparam int D = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int PUSH_AT = C * NBITS - 5;

    logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, ready = 1'b0;
    logic [7:0] data;
    logic valid, frame_err, overrun;
    logic [2:0] count;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
`endif

    uart_rx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .o_data(data), .o_valid(valid),
        .i_ready(ready), .o_count(count), .o_frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(parity_err),
`endif
        .o_overrun(overrun));

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    int fe_seen = 0, ov_seen = 0, pe_seen = 0;
    int exp_fe = 0, exp_ov = 0, exp_pe = 0;
    logic [7:0] q[$];

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_seen++;
        if (overrun === 1'b1) ov_seen++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) pe_seen++;
`endif
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ":count"}, 32'(count), q.size());
        check({tag, ":valid"}, 32'(valid), 32'(q.size() != 0));
        if (q.size() != 0) check({tag, ":data"}, 32'(data), 32'(q[0]));
        check({tag, ":frame_err"}, fe_seen, exp_fe);
        check({tag, ":overrun"}, ov_seen, exp_ov);
        check({tag, ":parity_err"}, pe_seen, exp_pe);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        cycles(C);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d ^ par_flip);
`endif
        send_bit(stop_bit);
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip, input logic pop_same);
        logic bad_par;
`ifdef UART_RX_PARITY_EN
        bad_par = par_flip;
`else
        bad_par = 1'b0;
`endif
        if (!stop_bit) exp_fe++;
        if (bad_par) exp_pe++;
        if (stop_bit && !bad_par) begin
            if (pop_same && q.size() != 0) void'(q.pop_front());
            if (q.size() < D) q.push_back(d);
            else exp_ov++;
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        send_frame(d, stop_bit, par_flip);
        model_frame(d, stop_bit, par_flip, 1'b0);
        if (!stop_bit) begin
            send_bit(1'b0);
            send_bit(1'b1);
        end
    endtask

    task automatic pop_one();
        ready = 1'b1;
        cycles(1);
        ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic glitch(input int n);
        rx = 1'b0;
        cycles(n);
        rx = 1'b1;
        cycles(2 * C);
    endtask

    initial begin
        cycles(3);
        check("reset:count", 32'(count), 0);
        check("reset:valid", 32'(valid), 0);
        check("reset:data", 32'(data), 0);
        check("reset:frame_err", 32'(frame_err), 0);
        check("reset:overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        cycles(2 * C);

        send_frame(8'h55, 1'b1, 1'b0); model_frame(8'h55, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0); model_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        check_state("b2b");
        pop_one();
        check_state("b2b_pop");
        pop_one();

        glitch(5);
        check_state("glitch");
        rx_frame(8'h3C, 1'b1, 1'b0);
        check_state("after_glitch");
        pop_one();

        send_frame(8'hF0, 1'b0, 1'b0); model_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        cycles(40 * C);
        rx = 1'b1;
        cycles(2 * C);
        check_state("break");
        rx_frame(8'h12, 1'b1, 1'b0);
        check_state("after_break");
        pop_one();

        for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1, 1'b0);
        check_state("overrun");

        fork
            send_frame(8'h06, 1'b1, 1'b0);
            begin
                cycles(PUSH_AT);
                ready = 1'b1;
                cycles(1);
                ready = 1'b0;
            end
        join
        model_frame(8'h06, 1'b1, 1'b0, 1'b1);
        check_state("full_push_pop");
        for (int i = 0; i < 2; i++) begin
            pop_one();
            check_state("read_order");
        end

        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'(8'h77 >> i));
        rst_n = 1'b0;
        #1;
        check("midreset:valid", 32'(valid), 0);
        check("midreset:count", 32'(count), 0);
        q.delete();
        rx = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(3 * C);
        rx = 1'b1;
        cycles(2 * C);
        check_state("low_release");
        rx_frame(8'h88, 1'b1, 1'b0);
        check_state("after_reset");
        pop_one();
`ifdef UART_RX_PARITY_EN
        rx_frame(8'h07, 1'b1, 1'b1);
        check_state("parity_err");
`endif

        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            logic stop_bit, par_flip;
            d = 8'($urandom);
            stop_bit = ($urandom_range(0, 4) != 0);
            par_flip = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, 6));
            rx_frame(d, stop_bit, par_flip);
            cycles($urandom_range(0, 20));
            repeat ($urandom_range(0, 2)) pop_one();
            check_state("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for the SoC's uartN_rx pins: the receive end of the 8N1 serial link that the SoC transmitters drive.
- Synchronises the asynchronous rx line and detects start bits.
- Samples each bit at its midpoint, checks the stop bit, and buffers bytes in a first-word-fall-through FIFO with a valid/ready output.
- Sits between the board-level rx pin and the SoC peripheral bus register logic.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per bit (25 MHz / 115200); must be >= 8.
- FIFO_DEPTH, 8, receive FIFO entries; power of two, >= 2.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_rx  input  1  serial line, idle high, asynchronous to i_clk
- o_data  output  8  FIFO head byte; valid only while o_valid = 1
- o_valid  output  1  FIFO non-empty
- i_ready  input  1  consumer pop; a pop occurs when o_valid && i_ready
- o_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low
- o_overrun  output  1  one-cycle pulse: byte dropped because FIFO full

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - Synchroniser flops reset to 1.
  - FSM returns to IDLE; counters cleared; FIFO emptied.
  - o_valid=0, o_data=0, o_count=0, o_frame_err=0, o_overrun=0.
  - A reset mid-frame discards the partial byte. After release, the receiver waits for a fresh falling edge; a line already low does not start a frame.
- Synchroniser: 2 flops on i_rx gives rx_s. The FSM sees only rx_s; there is a fixed 2-cycle input latency.
- FSM states:
  - IDLE: on rx_s falling edge (previous 1, now 0) -> START, bit counter loaded with CLKS_PER_BIT/2 - 1.
  - START: at counter expiry, sample rx_s. If 0 -> DATA, bit index 0, counter CLKS_PER_BIT-1. If 1 (glitch/false start) -> IDLE, no error flagged.
  - DATA: at each expiry, shift rx_s in LSB first and reload the counter. After bit 7 -> STOP (or PARITY with the option).
  - STOP: at expiry, sample rx_s.
    - If 1: push byte -> IDLE.
    - If 0: pulse o_frame_err, discard byte -> BREAK.
  - BREAK: wait for rx_s == 1 -> IDLE. Held-low lines (break) produce exactly one o_frame_err.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with a stop bit length of 0.5 bit or more.
- Push timing: FIFO written on the clock edge after the stop-bit sample. o_valid and o_count update the following cycle.
- FIFO: first-word fall-through; o_data = head entry (registered storage, read-pointer indexed). Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by o_count.
- Boundary cases:
  - Pop when empty: ignored.
  - Push when full and no pop in the same cycle: byte dropped, o_overrun pulses 1 cycle, contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overrun, count unchanged.
  - Push and pop in the same cycle while empty: push only (o_valid was 0).
  - Push and pop in the same cycle otherwise: count unchanged.
- o_frame_err and o_overrun never assert in the same cycle as reset deassertion.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP. It samples one extra bit at midpoint, and the frame becomes 8E1 (even parity).
  - Adds output port o_parity_err (1 bit, reset 0). On mismatch it pulses for one cycle at the stop-bit sample and the byte is discarded (not pushed).
  - A frame with both errors pulses o_frame_err and o_parity_err together.
- Undefined: no PARITY state, no o_parity_err port, and the frame is 8N1.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
1. Send 0x55 then 0xA3 back-to-back with 1 stop bit, i_ready=0 -> o_count=2, o_data=0x55. Pulse i_ready 1 cycle -> o_data=0xA3, o_count=1. No error pulses.
2. Drive i_rx low for 5 cycles then high (glitch) -> FSM returns to IDLE; o_count=0, no o_frame_err. A following 0x3C frame is received correctly.
3. Send 0xF0 with stop bit low, then hold the line low for 40 bit times -> exactly one o_frame_err pulse, o_count=0. Return high, send 0x12 -> o_data=0x12.
4. i_ready=0, send 0x01..0x05 -> o_count=4, one o_overrun pulse during byte 0x05, FIFO holds 0x01..0x04.
5. FIFO full with i_ready held 1 exactly in the push cycle of byte 0x06 -> no o_overrun, o_count stays 4. Read order is 0x02,0x03,0x04,0x06.
6. Assert i_rst_n=0 mid-DATA of 0x77 with 2 bytes buffered -> o_valid=0, o_count=0 immediately. After release, send 0x88 -> single byte 0x88, no errors. With UART_RX_PARITY_EN, also send 0x07 with parity 0 -> o_parity_err pulses, byte discarded.
